// File: rtl/fifo64_unpacker.sv
// fifo64_unpacker: drains a 64-bit FIFO (1-cycle read latency) into a 32-bit valid/ready stream.
// Optional macro FIFO64_UNPACKER_PREFETCH_EN adds a one-entry prefetch register for 1 word/cycle.
module fifo64_unpacker #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_fifo_empty,
    output logic        o_fifo_read,
    input  logic [63:0] i_fifo_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic [15:0] o_word_count
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_FIRST  = 2'd2;
    localparam logic [1:0] ST_SECOND = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [63:0] hold_r;
    logic [15:0] word_count_r;
    logic        handshake_s;
    logic [31:0] first_half_s;
    logic [31:0] second_half_s;

`ifdef FIFO64_UNPACKER_PREFETCH_EN
    logic [63:0] next_r;
    logic        next_valid_r;
    logic        inflight_r;
    logic        pf_issue_s;
`endif

    assign o_valid       = (state_r == ST_FIRST) || (state_r == ST_SECOND);
    assign o_last        = (state_r == ST_SECOND);
    assign o_word_count  = word_count_r;
    assign handshake_s   = o_valid & i_ready;
    assign first_half_s  = HIGH_FIRST ? hold_r[63:32] : hold_r[31:0];
    assign second_half_s = HIGH_FIRST ? hold_r[31:0]  : hold_r[63:32];

    // Output word select; zero outside the two emitting states
    always_comb begin
        o_data = 32'd0;
        case (state_r)
            ST_FIRST:  o_data = first_half_s;
            ST_SECOND: o_data = second_half_s;
            default:   o_data = 32'd0;
        endcase
    end

    // Next-state and read-strobe decode; a read is never issued while the FIFO is empty
    always_comb begin
        state_nxt_s = state_r;
        o_fifo_read = 1'b0;
`ifdef FIFO64_UNPACKER_PREFETCH_EN
        pf_issue_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!i_fifo_empty) begin
                    o_fifo_read = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_FIRST;
            ST_FIRST: begin
`ifdef FIFO64_UNPACKER_PREFETCH_EN
                pf_issue_s  = !next_valid_r && !inflight_r && !i_fifo_empty;
                o_fifo_read = pf_issue_s;
`endif
                if (handshake_s) begin
                    state_nxt_s = ST_SECOND;
                end else begin
                    state_nxt_s = ST_FIRST;
                end
            end
            ST_SECOND: begin
                if (handshake_s) begin
`ifdef FIFO64_UNPACKER_PREFETCH_EN
                    if (next_valid_r || inflight_r) begin
                        state_nxt_s = ST_FIRST;
                    end else if (!i_fifo_empty) begin
                        o_fifo_read = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`else
                    if (!i_fifo_empty) begin
                        o_fifo_read = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`endif
                end else begin
`ifdef FIFO64_UNPACKER_PREFETCH_EN
                    pf_issue_s  = !next_valid_r && !inflight_r && !i_fifo_empty;
                    o_fifo_read = pf_issue_s;
`endif
                    state_nxt_s = ST_SECOND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and handed-off word counter
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            word_count_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (handshake_s) begin
                word_count_r <= word_count_r + 16'd1;
            end
        end
    end

`ifdef FIFO64_UNPACKER_PREFETCH_EN
    // Hold/next registers: prefetched data goes straight to hold when the entry boundary coincides
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_r       <= 64'd0;
            next_r       <= 64'd0;
            next_valid_r <= 1'b0;
            inflight_r   <= 1'b0;
        end else begin
            if (state_r == ST_FETCH) begin
                hold_r <= i_fifo_rdata;
            end else if ((state_r == ST_SECOND) && handshake_s && next_valid_r) begin
                hold_r       <= next_r;
                next_valid_r <= 1'b0;
            end else if ((state_r == ST_SECOND) && handshake_s && inflight_r) begin
                hold_r     <= i_fifo_rdata;
                inflight_r <= 1'b0;
            end else if (inflight_r) begin
                next_r       <= i_fifo_rdata;
                next_valid_r <= 1'b1;
                inflight_r   <= 1'b0;
            end else if (pf_issue_s) begin
                inflight_r <= 1'b1;
            end
        end
    end
`else
    // Hold register loads on the cycle after the read strobe
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_r <= 64'd0;
        end else if (state_r == ST_FETCH) begin
            hold_r <= i_fifo_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_fifo64_unpacker.sv
// Directed self-checking bench for fifo64_unpacker with a behavioural registered-read FIFO.
module tb_fifo64_unpacker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic        fifo_read;
    logic [63:0] fifo_rdata = 64'd0;
    logic        valid;
    logic        ready = 1'b1;
    logic [31:0] data;
    logic        last;
    logic [15:0] wcount;

    logic [63:0] mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int unsigned read_cnt = 0;
    int          cyc = 0;
    logic [31:0] out_data[$];
    bit          out_last[$];
    int          out_cyc[$];
    int          checks = 0;
    int          failures = 0;

    fifo64_unpacker #(.HIGH_FIRST(1'b0)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_fifo_empty (fifo_empty),
        .o_fifo_read  (fifo_read),
        .i_fifo_rdata (fifo_rdata),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_data       (data),
        .o_last       (last),
        .o_word_count (wcount)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: registered read port, flushed while reset is held
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read) begin
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Stream monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read) read_cnt <= read_cnt + 1;
        if (rst_n && valid && ready) begin
            out_data.push_back(data);
            out_last.push_back(last);
            out_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (out_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_words", 64'(out_data.size() >= n), 64'd1);
    endtask

    initial begin
        int base;
        int r0;
        logic [63:0] e;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 32'd0);
        chk("rst_wcount", wcount, 16'd0);
        chk("rst_read", fifo_read, 1'b0);

        // Single entry, latency and order
        push(64'h11223344_AABBCCDD);
        #1;
        chk("single_read_strobe", fifo_read, 1'b1);
        @(negedge clk);
        chk("single_fetch_novalid", valid, 1'b0);
        @(negedge clk);
        chk("single_w0_valid", valid, 1'b1);
        chk("single_w0_data", data, 32'hAABBCCDD);
        chk("single_w0_last", last, 1'b0);
        @(negedge clk);
        chk("single_w1_data", data, 32'h11223344);
        chk("single_w1_last", last, 1'b1);
        @(negedge clk);
        chk("single_idle", valid, 1'b0);
        chk("single_wcount", wcount, 16'd2);
        chk("single_reads", read_cnt, 1);

        // Backpressure in FIRST with a second entry waiting
        ready = 1'b0;
        base = out_data.size();
        push(64'h55667788_99AABBCC);
        repeat (2) @(negedge clk);
        push(64'h0F0E0D0C_0B0A0908);
        r0 = read_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", valid, 1'b1);
            chk("bp_data", data, 32'h99AABBCC);
        end
`ifdef FIFO64_UNPACKER_PREFETCH_EN
        chk("bp_reads", read_cnt - r0, 1);
`else
        chk("bp_reads", read_cnt - r0, 0);
`endif
        ready = 1'b1;
        wait_words(base + 4, 20);
        chk("bp_w0", out_data[base],     32'h99AABBCC);
        chk("bp_w1", out_data[base + 1], 32'h55667788);
        chk("bp_w2", out_data[base + 2], 32'h0B0A0908);
        chk("bp_w3", out_data[base + 3], 32'h0F0E0D0C);
        chk("bp_l1", out_last[base + 1], 1'b1);
        chk("bp_l2", out_last[base + 2], 1'b0);
        repeat (2) @(negedge clk);
        chk("bp_wcount", wcount, 16'd6);

        // Empty guard for 100 cycles
        r0 = read_cnt;
        begin
            logic seen_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                seen_valid = seen_valid | valid | fifo_read;
            end
            chk("empty_reads", read_cnt - r0, 0);
            chk("empty_valid", seen_valid, 1'b0);
        end

        // Stream of 8 entries
        base = out_data.size();
        for (int i = 0; i < 8; i++) push({32'hA0000000 + 32'(i), 32'h50000000 + 32'(i)});
        wait_words(base + 16, 80);
        for (int i = 0; i < 8; i++) begin
            e = {32'hA0000000 + 32'(i), 32'h50000000 + 32'(i)};
            chk("stream_lo", out_data[base + 2 * i],     e[31:0]);
            chk("stream_hi", out_data[base + 2 * i + 1], e[63:32]);
            chk("stream_last", out_last[base + 2 * i + 1], 1'b1);
        end
`ifdef FIFO64_UNPACKER_PREFETCH_EN
        chk("stream_span", out_cyc[base + 15] - out_cyc[base], 15);
`else
        chk("stream_span", out_cyc[base + 15] - out_cyc[base], 22);
`endif
        chk("stream_wcount", wcount, 16'd22);
        repeat (2) @(negedge clk);

        // Word counter wrap
        force dut.word_count_r = 16'hFFFF;
        @(negedge clk);
        release dut.word_count_r;
        @(negedge clk);
        chk("wrap_preload", wcount, 16'hFFFF);
        base = out_data.size();
        push(64'h87654321_12345678);
        wait_words(base + 1, 10);
        chk("wrap_zero", wcount, 16'd0);
        wait_words(base + 2, 10);
        chk("wrap_one", wcount, 16'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-FIRST
        ready = 1'b0;
        push(64'hDEADBEEF_CAFEF00D);
        repeat (2) @(negedge clk);
        chk("mid_valid_before", valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 1'b0);
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_wcount", wcount, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        base = out_data.size();
        repeat (5) @(negedge clk);
        chk("post_rst_idle", valid, 1'b0);
        chk("post_rst_nowords", out_data.size(), base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
